// File: rtl/apb_regfile_slave_pkg.sv
// apb_regfile_slave_pkg
// Shared definitions for the APB register-file responder: bus widths,
// register-map indices, wait-counter width and the FSM state encoding.
package apb_regfile_slave_pkg;

  localparam int PADDR_WIDTH    = 32;
  localparam int APB_DATA_WIDTH = 32;

  // paddr[4:2] selects one of eight word registers
  localparam int REG_IDX_W = 3;
  localparam int NUM_RW    = 6;

  localparam logic [REG_IDX_W-1:0] REG_ID  = 3'd6;
  localparam logic [REG_IDX_W-1:0] REG_CNT = 3'd7;

  // Wide enough for the 0..15 wait-state range
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  function automatic logic is_ro_idx(input logic [REG_IDX_W-1:0] idx);
    return (idx == REG_ID) || (idx == REG_CNT);
  endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// apb_wait_ctr
// Loadable down-counter used to pace APB wait states.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset (count -> 0)
//   load      load load_val (has priority over dec)
//   load_val  value to load
//   dec       decrement by one; holds at zero
//   done      high while the count equals 1 (last wait cycle)
module apb_wait_ctr #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave
// APB responder with six read/write scratch registers, a read-only ID
// register (index 6) and a read-only completed-transfer counter (index 7).
// A programmable number of wait states is inserted before pready, and
// misaligned, out-of-range or read-only-write accesses answer with pslverr.
// Ports:
//   hclk     rising-edge clock
//   hreset   asynchronous active-high reset
//   psel     slave select
//   penable  APB access phase
//   pwrite   1 = write, 0 = read
//   paddr    byte address (paddr[4:2] = register index)
//   pwdata   write data
//   prdata   read data, valid while pready = 1 (0 on error / write)
//   pready   transfer completes this cycle (registered)
//   pslverr  error response, valid while pready = 1 (registered)
module apb_regfile_slave
  import apb_regfile_slave_pkg::*;
#(
  parameter int unsigned                WAIT_CYCLES = 2,
  parameter logic [APB_DATA_WIDTH-1:0]  ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                      hclk,
  input  logic                      hreset,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [PADDR_WIDTH-1:0]    paddr,
  input  logic [APB_DATA_WIDTH-1:0] pwdata,
  output logic [APB_DATA_WIDTH-1:0] prdata,
  output logic                      pready,
  output logic                      pslverr
);

  state_t state, state_nxt;

  logic setup, access;
  logic addr_err;
  logic wait_done;

  // Transfer attributes latched at the setup edge
  logic [REG_IDX_W-1:0]      idx_q;
  logic                      wr_q;
  logic [APB_DATA_WIDTH-1:0] wdata_q;
  logic                      err_q;

  // Attributes seen by the response logic: live bus in IDLE (zero-wait
  // entry to READY happens on the setup edge itself), latched otherwise.
  logic [REG_IDX_W-1:0]      idx_sel;
  logic                      wr_sel;
  logic                      err_sel;

  logic [APB_DATA_WIDTH-1:0] regs_q [NUM_RW];
  logic [APB_DATA_WIDTH-1:0] xfer_cnt;
  logic [APB_DATA_WIDTH-1:0] rd_mux;

  logic                      enter_ready;
  logic                      commit;
  logic                      pready_nxt;
  logic                      pslverr_nxt;
  logic [APB_DATA_WIDTH-1:0] prdata_nxt;

  assign setup  = psel & ~penable;
  assign access = psel & penable;

  assign addr_err = (paddr[1:0] != 2'b00)
                  | (|paddr[PADDR_WIDTH-1:5])
                  | (pwrite & is_ro_idx(paddr[4:2]));

  apb_wait_ctr #(
    .CNT_W (WAIT_CNT_W)
  ) u_wait_ctr (
    .clk      (hclk),
    .rst      (hreset),
    .load     ((state == ST_IDLE) && setup),
    .load_val (WAIT_CNT_W'(WAIT_CYCLES)),
    .dec      ((state == ST_WAIT) && access),
    .done     (wait_done)
  );

  // State and registered response outputs
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state   <= ST_IDLE;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      state   <= state_nxt;
      pready  <= pready_nxt;
      pslverr <= pslverr_nxt;
      prdata  <= prdata_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (setup) begin
          state_nxt = (WAIT_CYCLES == 0) ? ST_READY : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!psel) begin
          state_nxt = ST_IDLE;
        end else if (access && wait_done) begin
          state_nxt = ST_READY;
        end
      end
      ST_READY: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_sel     = (state == ST_IDLE) ? paddr[4:2] : idx_q;
    wr_sel      = (state == ST_IDLE) ? pwrite     : wr_q;
    err_sel     = (state == ST_IDLE) ? addr_err   : err_q;
    enter_ready = (state_nxt == ST_READY) && (state != ST_READY);
    pready_nxt  = enter_ready;
    pslverr_nxt = enter_ready & err_sel;
    prdata_nxt  = (enter_ready && !err_sel && !wr_sel) ? rd_mux : '0;
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (idx_sel == REG_IDX_W'(i)) rd_mux = regs_q[i];
    end
    if (idx_sel == REG_ID)  rd_mux = ID_VALUE;
    if (idx_sel == REG_CNT) rd_mux = xfer_cnt;
  end

  // Setup-phase capture; meaningful only once a transfer is under way
  always_ff @(posedge hclk) begin
    if ((state == ST_IDLE) && setup) begin
      idx_q   <= paddr[4:2];
      wr_q    <= pwrite;
      wdata_q <= pwdata;
      err_q   <= addr_err;
    end
  end

  // Commit at the closing edge of READY unless psel was dropped
  assign commit = (state == ST_READY) && psel && !err_q;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      for (int i = 0; i < NUM_RW; i++) regs_q[i] <= '0;
      xfer_cnt <= '0;
    end else if (commit) begin
      if (wr_q) begin
        for (int i = 0; i < NUM_RW; i++) begin
          if (idx_q == REG_IDX_W'(i)) regs_q[i] <= wdata_q;
        end
      end
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
module tb_apb_regfile_slave;
  import apb_regfile_slave_pkg::*;

  logic                      hclk;
  logic                      hreset;
  logic                      psel;
  logic                      psel0;
  logic                      penable;
  logic                      pwrite;
  logic [PADDR_WIDTH-1:0]    paddr;
  logic [APB_DATA_WIDTH-1:0] pwdata;
  logic [APB_DATA_WIDTH-1:0] prdata, prdata0;
  logic                      pready, pready0;
  logic                      pslverr, pslverr0;

  int total = 0;
  int bad   = 0;

  apb_regfile_slave #(.WAIT_CYCLES(2)) dut (
    .hclk    (hclk),
    .hreset  (hreset),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  apb_regfile_slave #(.WAIT_CYCLES(0)) dut_w0 (
    .hclk    (hclk),
    .hreset  (hreset),
    .psel    (psel0),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata0),
    .pready  (pready0),
    .pslverr (pslverr0)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    hreset = 1'b1;
    repeat (2) @(posedge hclk);
    #1;
    hreset = 1'b0;
  endtask

  // One transfer on the WAIT_CYCLES=2 instance; the address and write data
  // are scrambled after setup since the slave must use the latched copies.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int acc);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge hclk); #1;
    penable = 1'b1; paddr = addr ^ 32'h14; pwdata = ~wd; acc = 1;
    while (!pready && acc < 20) begin
      @(posedge hclk); #1;
      acc++;
    end
    rd = prdata; err = pslverr;
    @(posedge hclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic run(input string tag, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd);
    logic [31:0] rd;
    logic        err;
    int          acc;
    xfer(wr, addr, wd, rd, err, acc);
    chk({tag, ".latency"}, 32'(acc), 32'd3);
    chk({tag, ".pslverr"}, 32'(err), 32'(exp_err));
    if (!wr || exp_err) chk({tag, ".prdata"}, rd, exp_rd);
    chk({tag, ".pready_clr"}, 32'(pready), 32'd0);
  endtask

  initial begin
    logic seen;
    hreset = 1'b1; psel = 1'b0; psel0 = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddr = '0; pwdata = '0;

    // Reset state
    repeat (3) @(posedge hclk);
    #1;
    chk("rst.pready",  32'(pready),  32'd0);
    chk("rst.pslverr", 32'(pslverr), 32'd0);
    chk("rst.prdata",  prdata,       32'd0);
    chk("rst.pready0", 32'(pready0), 32'd0);
    hreset = 1'b0;
    @(posedge hclk); #1;

    // ID read with two wait states
    run("id_rd", 1'b0, 32'h18, 32'h0, 1'b0, 32'hA5B0_0001);

    // Fresh reset, write then back-to-back read, then counter
    do_reset();
    run("wr08",   1'b1, 32'h08, 32'hDEAD_BEEF, 1'b0, 32'h0);
    run("rd08",   1'b0, 32'h08, 32'h0,         1'b0, 32'hDEAD_BEEF);
    run("cnt_a",  1'b0, 32'h1C, 32'h0,         1'b0, 32'd2);

    // Illegal accesses
    run("wr1c",   1'b1, 32'h1C, 32'h0000_0055, 1'b1, 32'h0);
    run("wr20",   1'b1, 32'h20, 32'h1111_2222, 1'b1, 32'h0);
    run("rd02",   1'b0, 32'h02, 32'h0,         1'b1, 32'h0);
    run("wr18",   1'b1, 32'h18, 32'h3333_4444, 1'b1, 32'h0);
    run("cnt_b",  1'b0, 32'h1C, 32'h0,         1'b0, 32'd3);
    run("rd08b",  1'b0, 32'h08, 32'h0,         1'b0, 32'hDEAD_BEEF);
    run("rd00",   1'b0, 32'h00, 32'h0,         1'b0, 32'h0);
    run("rd18",   1'b0, 32'h18, 32'h0,         1'b0, 32'hA5B0_0001);

    // Abort during WAIT
    run("wr0c",   1'b1, 32'h0C, 32'h0BAD_F00D, 1'b0, 32'h0);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h1234_5678;
    @(posedge hclk); #1;
    penable = 1'b1;
    seen = pready;
    @(posedge hclk); #1;
    seen |= pready;
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge hclk); #1;
      seen |= pready;
    end
    chk("abort.pready", 32'(seen), 32'd0);
    run("rd0c",   1'b0, 32'h0C, 32'h0,         1'b0, 32'h0BAD_F00D);
    run("cnt_c",  1'b0, 32'h1C, 32'h0,         1'b0, 32'd9);

    // Zero-wait instance: two-cycle transfers
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h5A5A_0004;
    @(posedge hclk); #1;
    penable = 1'b1;
    chk("w0.wr.pready",  32'(pready0),  32'd1);
    chk("w0.wr.pslverr", 32'(pslverr0), 32'd0);
    @(posedge hclk); #1;
    psel0 = 1'b0; penable = 1'b0;
    chk("w0.wr.clr", 32'(pready0), 32'd0);
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h04;
    @(posedge hclk); #1;
    penable = 1'b1;
    chk("w0.rd.pready", 32'(pready0), 32'd1);
    chk("w0.rd.prdata", prdata0,      32'h5A5A_0004);
    @(posedge hclk); #1;
    paddr = 32'h1C;
    penable = 1'b0;
    @(posedge hclk); #1;
    penable = 1'b1;
    chk("w0.cnt.prdata", prdata0, 32'd2);
    @(posedge hclk); #1;
    psel0 = 1'b0; penable = 1'b0;

    // Counter wrap via backdoor preload
    dut.xfer_cnt = 32'hFFFF_FFFF;
    @(posedge hclk); #1;
    run("wrap_a", 1'b0, 32'h1C, 32'h0, 1'b0, 32'hFFFF_FFFF);
    run("wrap_b", 1'b0, 32'h1C, 32'h0, 1'b0, 32'h0);

    // Reset asserted in the READY cycle of a write
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hCAFE_0000;
    @(posedge hclk); #1;
    penable = 1'b1;
    for (int i = 0; i < 20 && !pready; i++) begin
      @(posedge hclk); #1;
    end
    chk("mrst.ready", 32'(pready), 32'd1);
    #2 hreset = 1'b1;
    #1;
    chk("mrst.pready",  32'(pready),  32'd0);
    chk("mrst.pslverr", 32'(pslverr), 32'd0);
    @(posedge hclk); #1;
    psel = 1'b0; penable = 1'b0; hreset = 1'b0;
    @(posedge hclk); #1;
    run("rd10",   1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
    run("cnt_d",  1'b0, 32'h1C, 32'h0, 1'b0, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_regfile_slave.md
# apb_regfile_slave

APB responder that terminates the APB side of the AHB-to-APB bridge. It is the reference peripheral behind one `psel_x` line. It decodes `paddr`, holds eight 32-bit registers (six read/write, two read-only), and inserts a programmable number of wait states through `pready`. It flags illegal accesses on `pslverr`, so the bridge's `pready_x`/`pslverr_x` paths can be exercised end to end.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: wait states inserted before `pready`. Legal range 0..15.
- `ID_VALUE`, default 32'hA5B0_0001: constant returned by register 6.

Ports:
- `hclk`  in  1  system clock; all logic is on the rising edge.
- `hreset`  in  1  asynchronous, active-high reset.
- `psel`  in  1  slave select from the bridge (`psel_en` decoded).
- `penable`  in  1  APB access phase.
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  `PADDR_WIDTH`  byte address.
- `pwdata`  in  `APB_DATA_WIDTH`  write data.
- `prdata`  out  `APB_DATA_WIDTH`  read data; valid only while `pready`=1.
- `pready`  out  1  transfer completes this cycle.
- `pslverr`  out  1  error response; valid only while `pready`=1.

## Operation
- Register map (`paddr[4:2]` = index):
  - 0–5: read/write scratch registers.
  - 6: ID, read-only, returns `ID_VALUE`.
  - 7: XFER_CNT, read-only. Increments by 1 on every error-free completed transfer (read or write) and wraps 32'hFFFF_FFFF -> 0.
- An access is an error if any of these holds:
  - `paddr[1:0]` != 0
  - `paddr` >= 32
  - write to index 6 or 7
- On error: no register changes, XFER_CNT is not incremented, `prdata` = 0.
- FSM states and transitions:
  - IDLE -> WAIT when `psel`=1 and `penable`=0 (setup phase) and `WAIT_CYCLES`>0. The wait counter loads `WAIT_CYCLES`.
  - IDLE -> READY directly on setup when `WAIT_CYCLES`=0.
  - WAIT: the counter decrements while `psel`&`penable`. When the counter reaches 1, go to READY.
  - READY: `pready`=1 and `prdata`/`pslverr` are driven. A write commits at the closing edge of this cycle. Always returns to IDLE.
  - Abort: `psel` low in WAIT or READY -> IDLE. No write, no count, `pready` stays 0.
- Address, direction, write data and the error decision are captured at the setup edge. Later changes of `paddr`/`pwdata` do not affect the transfer.
- `pready`, `pslverr` and `prdata` are registered outputs. They are computed on entry to READY and cleared on leaving it.

## Timing
- Reset (asynchronous assert, synchronous-release edge): state = IDLE; `pready`=0, `pslverr`=0, `prdata`=0; regs 0–5 = 0; XFER_CNT = 0.
- Transfer length is 2+`WAIT_CYCLES` cycles from setup to the completing edge. `pready` rises in access cycle `WAIT_CYCLES`+1.
- Back-to-back: a new setup in the cycle right after READY is accepted with no idle cycle.
- Read-after-write to the same register returns the new value on the next transfer.
- Reset asserted mid-transfer: outputs clear immediately, and the pending write is dropped.
- Setup seen while not in IDLE is ignored; it is a protocol violation.

## Structure
- The shared defines header holds:
  - `PADDR_WIDTH`, `APB_DATA_WIDTH`
  - register index constants: `REG_ID`=6, `REG_CNT`=7
  - FSM state encodings: IDLE, WAIT, READY (2 bits)
- One sub-module is natural: `apb_wait_ctr`, a loadable down-counter with a `done` flag. It is reused by other APB peripherals.
- Decode, register storage and the response mux stay in the top module.

## Test plan
- Reset, then read index 6 with `WAIT_CYCLES`=2 -> `pready` high in the 3rd access cycle, `prdata`=32'hA5B0_0001, `pslverr`=0.
- Write 32'hDEAD_BEEF to 0x08, then read 0x08 back-to-back -> read returns 32'hDEAD_BEEF; XFER_CNT read afterwards = 2.
- Write to 0x1C (XFER_CNT), write to 0x20, read 0x02 -> each completes with `pslverr`=1 and `prdata`=0; register contents and XFER_CNT unchanged.
- `WAIT_CYCLES`=0 build: a write to 0x04 completes with `pready`=1 in the first access cycle; the 2-cycle transfer is verified.
- Drop `psel` during WAIT after writing 32'h1234_5678 to 0x0C -> `pready` never asserts, 0x0C keeps its old value, the FSM accepts the next setup.
- Preload XFER_CNT to 32'hFFFF_FFFF via backdoor force, then do one good read -> XFER_CNT = 0; also assert `hreset` mid-write -> outputs clear asynchronously and the target register stays 0.
